// File: rtl/if_fetch_pkg.sv
// Shared widths, stall index and state encodings for the IF fetch engine.
// Imported by if_fetch.
package if_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam int ByteBus     = 8;
    localparam int IfStallBit  = 1;

    localparam logic RstnEnable = 1'b0;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_DONE  = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: reads one 32-bit instruction as four byte reads,
// assembles it little-endian and presents it with its PC.
// Ports:
//   clk, rst          clock, async active-low reset
//   pc_i, pc_memreq_i PC and fetch request from the PC register
//   flush_i           PC redirect, aborts any fetch
//   stall_i           stall vector, bit 1 holds the IF output
//   mem_busy_o        engine occupied, PC must not advance
//   mem_req_o/addr_o  byte read request and address
//   mem_gnt_i         controller grant
//   mem_din_i         read data, one cycle after a granted read
//   inst_o/inst_pc_o  assembled instruction and its PC
//   inst_valid_o      instruction valid
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int IDX_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               pc_memreq_i,
    input  logic               flush_i,
    input  logic [5:0]         stall_i,
    output logic               mem_busy_o,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic [ByteBus-1:0] mem_din_i,
    output logic [InstBus-1:0] inst_o,
    output logic [ADDR_W-1:0]  inst_pc_o,
    output logic               inst_valid_o
);

    if_state_e          r_state;
    if_state_e          w_next;
    logic [ADDR_W-1:0]  r_base;
    logic [IDX_W-1:0]   r_issue_cnt;
    logic [IDX_W-1:0]   r_recv_cnt;
    logic               r_pending;
    logic [InstBus-1:0] r_inst;
    logic [ADDR_W-1:0]  r_inst_pc;
    logic               w_accept;
    logic               w_issue;
    logic               w_capture;
    logic               w_last;

    assign mem_busy_o   = (r_state != IF_IDLE);
    assign mem_req_o    = (r_state == IF_FETCH) &&
                          (r_issue_cnt < IDX_W'(4));
    assign mem_addr_o   = r_base + ADDR_W'(r_issue_cnt);
    assign inst_valid_o = (r_state == IF_DONE);
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;

    // A redirect overrides issue and capture in the same cycle so the
    // in-flight byte never lands in the assembler.
    assign w_accept  = (r_state == IF_IDLE) && pc_memreq_i && !flush_i;
    assign w_issue   = mem_req_o && mem_gnt_i && !flush_i;
    assign w_capture = (r_state == IF_FETCH) && r_pending && !flush_i;
    assign w_last    = w_capture && (r_recv_cnt == IDX_W'(3));

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstnEnable) begin
            r_state <= IF_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IF_IDLE: begin
                if (w_accept) w_next = IF_FETCH;
            end
            IF_FETCH: begin
                if (flush_i)     w_next = IF_IDLE;
                else if (w_last) w_next = IF_DONE;
            end
            IF_DONE: begin
                if (flush_i || !stall_i[IfStallBit]) w_next = IF_IDLE;
            end
            default: w_next = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstnEnable) begin
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_pending   <= 1'b0;
            r_inst      <= '0;
            r_inst_pc   <= '0;
        end else begin
            r_pending <= w_issue;
            if (w_accept) begin
                r_base      <= pc_i;
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
            end
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + IDX_W'(1);
            end
            if (w_capture) begin
                r_inst[{r_recv_cnt[1:0], 3'b000} +: 8] <= mem_din_i;
                r_recv_cnt <= r_recv_cnt + IDX_W'(1);
            end
            if (w_last) begin
                r_inst_pc <= r_base;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_memreq_i;
    logic        flush_i;
    logic [5:0]  stall_i;
    logic        mem_busy_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic [7:0]  mem_din_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] mem [256];

    // memory-side response
    logic        rd_flag = 1'b0;
    logic [31:0] rd_addr = '0;

    // model state: fetch in progress, base PC, reads granted,
    // bytes returned, byte in flight, word complete
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_pend = 1'b0;
    logic [31:0] m_base = '0;
    int          m_iss = 0;
    int          m_got = 0;

    if_fetch #(.ADDR_W(32), .IDX_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_memreq_i  (pc_memreq_i),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .mem_busy_o   (mem_busy_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_din_i    (mem_din_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] b);
        logic [31:0] a;
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            a = b + 32'(k);
            w[8*k +: 8] = mem[a[7:0]];
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (rd_flag) mem_din_i = mem[rd_addr[7:0]];
        else         mem_din_i = 8'($urandom);
    end

    // compare-then-advance model, once per cycle on the falling edge
    always @(negedge clk) begin
        logic        e_req;
        logic        newp;
        logic [31:0] e_addr;
        if (!rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_pend = 1'b0;
            m_iss  = 0;
            m_got  = 0;
            chk("rst inst", inst_o, 32'h0);
            chk("rst inst_pc", inst_pc_o, 32'h0);
        end
        e_req  = m_busy && !m_done && (m_iss < 4);
        e_addr = m_base + 32'(m_iss);
        chk("busy", mem_busy_o, m_busy);
        chk("req", mem_req_o, e_req);
        if (e_req) chk("addr", mem_addr_o, e_addr);
        chk("valid", inst_valid_o, m_done);
        if (m_done) begin
            chk("inst", inst_o, word_at(m_base));
            chk("inst_pc", inst_pc_o, m_base);
        end
        rd_flag = mem_req_o && mem_gnt_i;
        rd_addr = mem_addr_o;
        if (rst) begin
            if (flush_i) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                m_pend = 1'b0;
            end else if (!m_busy) begin
                if (pc_memreq_i) begin
                    m_busy = 1'b1;
                    m_base = pc_i;
                    m_iss  = 0;
                    m_got  = 0;
                    m_pend = 1'b0;
                end
            end else if (!m_done) begin
                newp = e_req && mem_gnt_i;
                if (m_pend) m_got++;
                if (newp)   m_iss++;
                m_pend = newp;
                if (m_got == 4) m_done = 1'b1;
            end else if (!stall_i[1]) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] wa [4];
        logic [31:0] w;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13;
        mem[1] = 8'h05;
        mem[2] = 8'h10;
        mem[3] = 8'h00;
        rst = 1'b0;
        pc_i = '0;
        pc_memreq_i = 1'b0;
        flush_i = 1'b0;
        stall_i = '0;
        mem_gnt_i = 1'b1;
        mem_din_i = '0;

        // reset state
        step();
        step();
        chk("reset busy", mem_busy_o, 1'b0);
        chk("reset req", mem_req_o, 1'b0);
        chk("reset addr", mem_addr_o, 32'h0);
        chk("reset valid", inst_valid_o, 1'b0);
        chk("reset inst", inst_o, 32'h0);
        rst = 1'b1;

        // basic fetch at 0, grant always high
        pc_i = 32'h0;
        pc_memreq_i = 1'b1;
        neg();
        chk("t1 busy c0", mem_busy_o, 1'b0);
        step();
        pc_memreq_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            neg();
            chk("t1 addr", mem_addr_o, 32'(c - 1));
            chk("t1 req", mem_req_o, 1'b1);
            chk("t1 busy", mem_busy_o, 1'b1);
            step();
        end
        neg();
        chk("t1 req c5", mem_req_o, 1'b0);
        chk("t1 valid c5", inst_valid_o, 1'b0);
        step();
        neg();
        chk("t1 valid c6", inst_valid_o, 1'b1);
        chk("t1 inst", inst_o, 32'h00100513);
        chk("t1 inst_pc", inst_pc_o, 32'h0);
        chk("t1 busy c6", mem_busy_o, 1'b1);
        step();
        neg();
        chk("t1 valid c7", inst_valid_o, 1'b0);
        chk("t1 busy c7", mem_busy_o, 1'b0);
        step();

        // grant withheld in cycles 2-3
        pc_memreq_i = 1'b1;
        step();
        pc_memreq_i = 1'b0;
        neg();
        chk("t2 addr c1", mem_addr_o, 32'h0);
        step();
        mem_gnt_i = 1'b0;
        neg();
        chk("t2 addr c2", mem_addr_o, 32'h1);
        chk("t2 req c2", mem_req_o, 1'b1);
        step();
        neg();
        chk("t2 addr c3", mem_addr_o, 32'h1);
        step();
        mem_gnt_i = 1'b1;
        repeat (3) begin
            neg();
            chk("t2 valid early", inst_valid_o, 1'b0);
            step();
        end
        neg();
        chk("t2 valid c7", inst_valid_o, 1'b0);
        step();
        neg();
        chk("t2 valid c8", inst_valid_o, 1'b1);
        chk("t2 inst", inst_o, 32'h00100513);
        step();

        // flush in cycle 3, refetch at 0x100
        pc_i = 32'h40;
        pc_memreq_i = 1'b1;
        step();
        pc_memreq_i = 1'b0;
        step();
        step();
        flush_i = 1'b1;
        pc_i = 32'h100;
        step();
        flush_i = 1'b0;
        pc_memreq_i = 1'b1;
        neg();
        chk("t3 req c4", mem_req_o, 1'b0);
        chk("t3 busy c4", mem_busy_o, 1'b0);
        chk("t3 valid c4", inst_valid_o, 1'b0);
        step();
        pc_memreq_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            neg();
            chk("t3 no valid", inst_valid_o, 1'b0);
            step();
        end
        neg();
        chk("t3 valid", inst_valid_o, 1'b1);
        chk("t3 inst", inst_o, 32'h00100513);
        chk("t3 inst_pc", inst_pc_o, 32'h100);
        step();

        // stall held in DONE for 3 cycles
        pc_i = 32'h8;
        pc_memreq_i = 1'b1;
        step();
        pc_memreq_i = 1'b0;
        repeat (5) step();
        stall_i = 6'b000010;
        w = word_at(32'h8);
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("t4 valid held", inst_valid_o, 1'b1);
            chk("t4 inst held", inst_o, w);
            chk("t4 pc held", inst_pc_o, 32'h8);
            step();
        end
        stall_i = '0;
        pc_i = 32'h20;
        pc_memreq_i = 1'b1;
        neg();
        chk("t4 valid c9", inst_valid_o, 1'b1);
        step();
        neg();
        chk("t4 valid c10", inst_valid_o, 1'b0);
        chk("t4 busy c10", mem_busy_o, 1'b0);
        step();
        pc_memreq_i = 1'b0;
        neg();
        chk("t4 busy c11", mem_busy_o, 1'b1);
        repeat (8) step();

        // address wrap
        wa[0] = 32'hFFFFFFFE;
        wa[1] = 32'hFFFFFFFF;
        wa[2] = 32'h00000000;
        wa[3] = 32'h00000001;
        pc_i = 32'hFFFFFFFE;
        pc_memreq_i = 1'b1;
        step();
        pc_memreq_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            neg();
            chk("t5 wrap addr", mem_addr_o, wa[c]);
            step();
        end
        step();
        neg();
        chk("t5 valid", inst_valid_o, 1'b1);
        chk("t5 inst", inst_o,
            {mem[1], mem[0], mem[8'hFF], mem[8'hFE]});
        step();

        // async reset mid-fetch
        pc_i = 32'h10;
        pc_memreq_i = 1'b1;
        step();
        pc_memreq_i = 1'b0;
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("t6 busy", mem_busy_o, 1'b0);
        chk("t6 req", mem_req_o, 1'b0);
        chk("t6 addr", mem_addr_o, 32'h0);
        chk("t6 valid", inst_valid_o, 1'b0);
        chk("t6 inst", inst_o, 32'h0);
        chk("t6 inst_pc", inst_pc_o, 32'h0);
        step();
        rst = 1'b1;
        pc_memreq_i = 1'b1;
        step();
        pc_memreq_i = 1'b0;
        repeat (5) step();
        neg();
        chk("t6 restart valid", inst_valid_o, 1'b1);
        chk("t6 restart inst", inst_o, word_at(32'h10));
        chk("t6 restart pc", inst_pc_o, 32'h10);
        step();

        // randomized traffic, model-checked
        for (int i = 0; i < 4000; i++) begin
            pc_memreq_i = ($urandom % 3) != 0;
            pc_i = (($urandom % 8) == 0) ?
                   32'hFFFFFFFC + 32'($urandom % 4) : 32'($urandom);
            mem_gnt_i = ($urandom % 4) != 0;
            flush_i = ($urandom % 20) == 0;
            stall_i = 6'($urandom);
            if ((i % 700) == 350) begin
                #2;
                rst = 1'b0;
            end
            step();
            rst = 1'b1;
        end
        flush_i = 1'b0;
        pc_memreq_i = 1'b0;
        stall_i = '0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch engine directly downstream of the PC register. Accepts the PC and its fetch request, then reads the instruction as four byte reads over the 8-bit memory-controller port. Assembles the little-endian 32-bit word and presents it with its PC to the IF/ID boundary. Drives the busy handshake that gates PC advance, and aborts cleanly on a PC redirect.

Parameters:
ADDR_W, 32, width of instruction address and memory address bus
IDX_W, 3, width of internal byte counters (must hold 0..4)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
pc_i  in  ADDR_W  current PC from PC register
pc_memreq_i  in  1  PC register requests a fetch of pc_i
flush_i  in  1  PC redirect this cycle (same signal that loads a new PC)
stall_i  in  6  pipeline stall vector; bit 1 holds the IF output
mem_busy_o  out  1  fetch engine occupied; PC register must not advance
mem_req_o  out  1  byte-read request to memory controller
mem_addr_o  out  ADDR_W  byte address of the read
mem_gnt_i  in  1  controller grants the port this cycle
mem_din_i  in  8  read data, valid the cycle after a granted read
inst_o  out  32  assembled instruction
inst_pc_o  out  ADDR_W  PC of inst_o
inst_valid_o  out  1  inst_o/inst_pc_o valid this cycle

Behaviour:
- Reset (rst=0, async): state IDLE, counters 0, inst_o=0, inst_pc_o=0, inst_valid_o=0, mem_req_o=0, mem_busy_o=0, pending flag 0.
- States: IDLE, FETCH, DONE.
- mem_busy_o = (state != IDLE), combinational.
- IDLE:
  - accept when pc_memreq_i=1 and flush_i=0; latch base=pc_i, issue_cnt=0, recv_cnt=0, go FETCH.
  - PC register advances on the same edge; this is intended.
  - flush_i=1 in IDLE blocks acceptance because pc_i is stale that cycle.
- FETCH:
  - mem_req_o = (issue_cnt<4); mem_addr_o = base + issue_cnt, mod 2^ADDR_W (wraps).
  - A read is issued in a cycle with mem_req_o=1 and mem_gnt_i=1; issue_cnt increments and pending sets for the next cycle.
  - With gnt=0, address held, nothing issued, pending clears.
  - When pending=1, mem_din_i is written to inst byte recv_cnt (byte k -> bits 8k+7:8k) and recv_cnt increments.
  - When the 4th byte is captured, go DONE; inst_pc_o=base.
- DONE:
  - inst_valid_o=1.
  - If stall_i[1]=0, return to IDLE at the next edge; valid lasts exactly one cycle.
  - If stall_i[1]=1, hold DONE with inst_o, inst_pc_o and valid stable.
- Latency, grant always high:
  - request sampled in cycle 0, reads issued cycles 1-4, bytes captured at ends of cycles 2-5.
  - inst_valid_o=1 in cycle 6; next accept possible in cycle 7.
- flush_i=1 in FETCH or DONE (priority over everything):
  - next state IDLE; inst_valid_o=0 from the next cycle; mem_req_o=0 from the next cycle.
  - In-flight return byte is discarded (pending cleared).
  - No partial instruction is ever presented.
- Grant drop mid-fetch only stretches latency; byte order and address sequence are unchanged.
- stall_i outside DONE has no effect; fetch continues so memory traffic completes.
- rst asserted mid-fetch: immediate return to reset values; mem_req_o falls asynchronously.

Decomposition:
- Shared defines: InstAddrBus, InstBus, ByteBus widths; IF stall bit index (1); new RstnEnable=1'b0 constant; state encodings IF_IDLE/IF_FETCH/IF_DONE.
- No sub-module needed. The byte assembler (4x8 register with write index) may be split out as if_byte_assembler if reused by the data-load path.

Test Plan:
- Reset, then pc_i=0x00000000 with req=1, gnt=1, RAM bytes 0x13,0x05,0x10,0x00 -> mem_addr_o 0,1,2,3 in cycles 1-4; inst_o=0x00100513, inst_pc_o=0, valid in cycle 6 only; mem_busy_o=1 cycles 1-6.
- Same fetch with gnt=0 in cycles 2-3 -> addresses held at 1 during the stall; valid in cycle 8; inst_o still 0x00100513.
- flush_i=1 in cycle 3 of a fetch -> mem_req_o=0 from cycle 4, no valid pulse, mem_busy_o=0 in cycle 4; next request at new PC 0x100 returns the word at 0x100.
- stall_i[1]=1 during DONE for 3 cycles -> inst_valid_o held 4 cycles with constant data; no new accept until stall drops.
- pc_i=0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001 (wrap).
- rst pulled low in cycle 3 of a fetch, between edges -> all outputs 0 immediately; fetch restarts cleanly after release.
